// File: rtl/aes_key_schedule_multi_if.sv
// aes_key_schedule_multi_if
//   Bundles the job-control and round-key read signals of the AES key
//   schedule.
//   master : job requester / round datapath (drives start, key_len, key,
//            rk_rd, rk_idx and, when AES_KS_EQINV_EN is defined, rk_eqinv).
//   slave  : the key schedule (drives busy, done, key_valid, cfg_err, nr,
//            rk_out).
//   Optional macro: AES_KS_EQINV_EN adds the rk_eqinv select.
interface aes_key_schedule_multi_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic         cfg_err;
  logic [3:0]   nr;
  logic         rk_rd;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
`ifdef AES_KS_EQINV_EN
  logic         rk_eqinv;
`endif

  modport master (
`ifdef AES_KS_EQINV_EN
    output rk_eqinv,
`endif
    output start, key_len, key, rk_rd, rk_idx,
    input  busy, done, key_valid, cfg_err, nr, rk_out
  );

  modport slave (
`ifdef AES_KS_EQINV_EN
    input  rk_eqinv,
`endif
    input  start, key_len, key, rk_rd, rk_idx,
    output busy, done, key_valid, cfg_err, nr, rk_out
  );
endinterface

// File: rtl/aes_key_schedule_multi.sv
// aes_key_schedule_multi
//   Iterative AES-128/192/256 key expansion. One 32-bit schedule word is
//   produced per step and kept in a 60-word register file; the round datapath
//   fetches 128-bit round keys by index through a registered read port.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus (slave): start/key_len/key   job request (sampled only when idle)
//                  busy/done/key_valid job status, done is a 1-cycle pulse
//                  cfg_err             1-cycle pulse on start with key_len=3
//                  nr                  Nr of current / last job
//                  rk_rd/rk_idx/rk_out round-key read, 1-cycle latency
//   Parameters:
//     SBOX_LAT  : 0 = combinational S-box, 1 = registered lookup (extra SUB cycle)
//     MAX_WORDS : storage depth, must be 60
//   Optional macro AES_KS_EQINV_EN: adds bus.rk_eqinv; middle rounds are
//   then returned through InvMixColumns (equivalent inverse cipher keys).
module aes_key_schedule_multi #(
  parameter int SBOX_LAT  = 1,
  parameter int MAX_WORDS = 60
) (
  input  logic                      clk,
  input  logic                      rst_n,
  aes_key_schedule_multi_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_SUB  = 2'd2;

  // Forward S-box, byte 0 in the top byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_ROM[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_KS_EQINV_EN
  // InvMixColumns on one column, built from xtime chains:
  // 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // State
  logic [1:0]   state_q, state_d;
  logic [5:0]   i_q, i_d;          // index of next word to write
  logic [2:0]   pos_q, pos_d;      // i mod Nk, tracked incrementally
  logic [7:0]   rcon_q, rcon_d;    // Rcon for the next rotate word
  logic [1:0]   kl_q, kl_d;
  logic [3:0]   nr_q, nr_d;
  logic         done_q, done_d;
  logic         kv_q, kv_d;
  logic         cfg_err_q, cfg_err_d;
  logic [31:0]  sub_q, sub_d;      // registered S-box result (SBOX_LAT=1)
  logic [127:0] rk_out_q, rk_out_d;
  logic [31:0]  w_q [MAX_WORDS];
  logic [31:0]  w_d [MAX_WORDS];

  // Word-generation datapath
  logic [5:0]  nk, nk_new, rd_base;
  logic [2:0]  nk_m1;
  logic [3:0]  nr_new;
  logic [31:0] w_prev, w_back, sub_in, sub_comb, sub_src, rcon_word, temp, new_word;
  logic        rot_case, sbox_case, last_word, wr_word;
  logic [127:0] rk_plain;

  always_comb begin
    unique case (kl_q)
      2'd0:    begin nk = 6'd4; nk_m1 = 3'd3; end
      2'd1:    begin nk = 6'd6; nk_m1 = 3'd5; end
      default: begin nk = 6'd8; nk_m1 = 3'd7; end
    endcase
    unique case (bus.key_len)
      2'd0:    begin nk_new = 6'd4; nr_new = 4'd10; end
      2'd1:    begin nk_new = 6'd6; nr_new = 4'd12; end
      default: begin nk_new = 6'd8; nr_new = 4'd14; end
    endcase
  end

  always_comb begin
    w_prev    = w_q[i_q - 6'd1];
    w_back    = w_q[i_q - nk];
    rot_case  = (pos_q == 3'd0);
    // AES-256 adds a plain SubWord halfway through each 8-word group.
    sbox_case = rot_case || (kl_q == 2'd2 && pos_q == 3'd4);
    sub_in    = rot_case ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_comb  = sub_word(sub_in);
    sub_src   = (SBOX_LAT == 1) ? sub_q : sub_comb;
    rcon_word = rot_case ? {rcon_q, 24'h0} : 32'h0;
    temp      = sbox_case ? (sub_src ^ rcon_word) : w_prev;
    new_word  = w_back ^ temp;
    last_word = (i_q == {nr_q, 2'b11});   // word 4*(Nr+1)-1
  end

  // Control FSM
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    pos_d     = pos_q;
    rcon_d    = rcon_q;
    kl_d      = kl_q;
    nr_d      = nr_q;
    done_d    = 1'b0;
    kv_d      = kv_q;
    cfg_err_d = 1'b0;
    sub_d     = sub_q;
    w_d       = w_q;
    wr_word   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.key_len == 2'd3) begin
            cfg_err_d = 1'b1;
          end else begin
            kl_d   = bus.key_len;
            nr_d   = nr_new;
            kv_d   = 1'b0;
            for (int k = 0; k < 8; k++)
              if (k < int'(nk_new)) w_d[6'(k)] = bus.key[255-32*k -: 32];
            i_d     = nk_new;
            pos_d   = 3'd0;
            rcon_d  = 8'h01;
            state_d = ST_GEN;
          end
        end
      end
      ST_GEN: begin
        if (sbox_case && SBOX_LAT == 1) begin
          sub_d   = sub_comb;
          state_d = ST_SUB;
        end else begin
          wr_word = 1'b1;
        end
      end
      ST_SUB:  wr_word = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    if (wr_word) begin
      w_d[i_q] = new_word;
      i_d      = i_q + 6'd1;
      pos_d    = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
      if (rot_case) rcon_d = xtime(rcon_q);
      if (last_word) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        kv_d    = 1'b1;
      end else begin
        state_d = ST_GEN;
      end
    end
  end

  // Round-key read port. Out-of-range indices read as zero, which also
  // hides stale words left over from a longer previous schedule.
  always_comb begin
    rk_out_d = rk_out_q;
    rd_base  = {bus.rk_idx, 2'b00};
    rk_plain = '0;
    if (bus.rk_rd) begin
      if (bus.rk_idx > nr_q) begin
        rk_out_d = '0;
      end else begin
        rk_plain = {w_q[rd_base], w_q[rd_base + 6'd1],
                    w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        rk_out_d = rk_plain;
`ifdef AES_KS_EQINV_EN
        if (bus.rk_eqinv && bus.rk_idx != 4'd0 && bus.rk_idx != nr_q)
          rk_out_d = {inv_mix_col(rk_plain[127:96]), inv_mix_col(rk_plain[95:64]),
                      inv_mix_col(rk_plain[63:32]),  inv_mix_col(rk_plain[31:0])};
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      pos_q     <= '0;
      rcon_q    <= 8'h01;
      kl_q      <= '0;
      nr_q      <= '0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      cfg_err_q <= 1'b0;
      sub_q     <= '0;
      rk_out_q  <= '0;
      for (int k = 0; k < MAX_WORDS; k++) w_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      pos_q     <= pos_d;
      rcon_q    <= rcon_d;
      kl_q      <= kl_d;
      nr_q      <= nr_d;
      done_q    <= done_d;
      kv_q      <= kv_d;
      cfg_err_q <= cfg_err_d;
      sub_q     <= sub_d;
      rk_out_q  <= rk_out_d;
      w_q       <= w_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.key_valid = kv_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.nr        = nr_q;
  assign bus.rk_out    = rk_out_q;

endmodule

// File: doc/aes_key_schedule_multi.md
Name: aes_key_schedule_multi

Overview:
- Iterative, parametrised AES key schedule supporting AES-128, AES-192 and AES-256, selected per job by a mode input.
- Generates one 32-bit schedule word per step and stores all Nb*(Nr+1) words in an internal register file.
- Exposes a registered round-key read port for the round datapath.
- Replaces the fixed 128-bit, 11-round expander; the round datapath reads keys by index instead of taking a flat 1408-bit bus.

Parameters:
- SBOX_LAT, 1, S-box read latency in cycles (0 = combinational, 1 = registered BRAM-style lookup); legal values 0 and 1.
- MAX_WORDS, 60, storage depth in 32-bit words; fixed at 60 (AES-256 requirement); other values are illegal.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request new expansion; sampled only while busy=0.
- key_len  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal.
- key  in  256  cipher key, MSB-aligned; AES-128 uses [255:128], AES-192 uses [255:64].
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse after the final word is written.
- key_valid  out  1  level; schedule complete and stable.
- cfg_err  out  1  one-cycle pulse when start is seen with key_len=3.
- nr  out  4  latched Nr of the current or last job (10/12/14).
- rk_rd  in  1  round-key read strobe.
- rk_idx  in  4  round index 0..nr.
- rk_out  out  128  round key; word 4r in [127:96] through word 4r+3 in [31:0].

Behaviour:
- Reset values: busy=0, done=0, key_valid=0, cfg_err=0, nr=0, rk_out=0, all storage words=0, FSM=IDLE. Reset asserted mid-job aborts the job immediately.
- FSM states: IDLE, GEN, SUB (SUB exists only when SBOX_LAT=1).
- IDLE, start=1, key_len<3:
  - On that edge, latch key_len and nr; write words 0..Nk-1 from key; clear key_valid.
  - Set busy=1; word counter i=Nk; go to GEN.
- IDLE, start=1, key_len=3: pulse cfg_err; no other state changes.
- start while busy=1: ignored; no error.
- Word rule:
  - Sub-word case: i mod Nk == 0, temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
  - Sub-only case: Nk==8 and i mod 8 == 4, temp = SubWord(w[i-1]).
  - Otherwise temp = w[i-1].
  - Result: w[i] = w[i-Nk] ^ temp.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Timing per word:
  - Non-S-box word: written at the end of one GEN cycle.
  - S-box word with SBOX_LAT=1: GEN issues the lookup, SUB writes the word (2 cycles).
  - S-box word with SBOX_LAT=0: 1 cycle.
- Total GEN+SUB cycles (SBOX_LAT=1): AES-128 50, AES-192 54, AES-256 65. With SBOX_LAT=0: 40, 46, 52.
- Completion: on the edge writing word 4*(Nr+1)-1, go to IDLE, busy=0, key_valid=1, and done=1 for exactly the next cycle.
- Timing reference: start seen in cycle 0 means done is high in cycle 1+total (AES-128, SBOX_LAT=1: cycle 51).
- Read port: when rk_rd=1, rk_out is updated on the next edge with words 4*rk_idx..4*rk_idx+3.
  - rk_idx > nr returns 128'h0.
  - Reads while busy=1 return current storage contents (partial schedule is legal, not guaranteed).
  - rk_out holds its value when rk_rd=0.
- Storage is not cleared on a new start; words beyond the new job's range keep stale data but are unreachable because of the rk_idx>nr rule.

Optional Feature:
- Macro: AES_KS_EQINV_EN.
- Defined:
  - Adds input rk_eqinv (1 bit).
  - When rk_eqinv=1 and 1 <= rk_idx <= nr-1, rk_out = InvMixColumns applied per 32-bit column to the stored round key (equivalent inverse cipher keys).
  - Rounds 0 and nr are returned unmodified.
  - Read latency stays 1 cycle.
- Not defined: no rk_eqinv port; rk_out is always the plain round key.

Test Plan:
- AES-128, key 2b7e1516_28aed2a6_abf71588_09cf4f3c, SBOX_LAT=1 -> done in cycle 51; rk_idx=1 gives a0fafe17_88542cb1_23a33939_2a6c7605; rk_idx=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6; nr=10.
- AES-192, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> nr=12; rk_idx=12 gives e98ba06f_448c773c_8ecc7204_01002202; rk_idx=13 gives 0.
- AES-256, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4 -> done after 65 GEN/SUB cycles; rk_idx=14 gives fe4890d1_e6188d0b_046df344_706c631e.
- key_len=3 with start -> cfg_err pulse for 1 cycle; busy stays 0; key_valid and storage unchanged. Then a second start with AES-128 while busy=1 -> the second start is ignored and the first job's results are correct.
- rst_n low at GEN cycle 20 -> busy=0, key_valid=0, rk_out=0 asynchronously. A fresh AES-128 job afterwards completes with correct round 10.
- AES_KS_EQINV_EN with the AES-128 key above -> rk_idx=0 and 10 with rk_eqinv=1 match the plain values; rk_idx 1..9 match a bench InvMixColumns model.
